// File: rtl/raster_box_source_if.sv
// Control inputs and DVAL-qualified pixel stream of the synthetic raster box source.
interface raster_box_source_if #(parameter int DATA_W = 10);
    logic              start;
    logic              cont;
    logic [15:0]       box_x0;
    logic [15:0]       box_x1;
    logic [15:0]       box_y0;
    logic [15:0]       box_y1;
    logic [DATA_W-1:0] box_level;
    logic [DATA_W-1:0] data;
    logic              dval;
    logic [15:0]       x;
    logic [15:0]       y;
    logic              frame_done;
    logic              busy;

    modport master (input  start, cont, box_x0, box_x1, box_y0, box_y1, box_level,
                    output data, dval, x, y, frame_done, busy);
    modport slave  (output start, cont, box_x0, box_x1, box_y0, box_y1, box_level,
                    input  data, dval, x, y, frame_done, busy);
endinterface

// File: rtl/raster_box_source.sv
// Raster pixel source: constant background with one programmable rectangle,
// emitted line by line with horizontal and vertical blanking.
module raster_box_source #(
    parameter int H_ACTIVE = 640,
    parameter int V_ACTIVE = 480,
    parameter int H_BLANK  = 16,
    parameter int V_BLANK  = 64,
    parameter int DATA_W   = 10,
    parameter int BG_LEVEL = 1023
) (
    input  logic                iCLK,
    input  logic                iRST,
    raster_box_source_if.master bus
);
    typedef enum logic [2:0] {IDLE, LINE, HBLANK, VBLANK, DONE} state_t;

    localparam logic [15:0]       X_LAST  = 16'(H_ACTIVE - 1);
    localparam logic [15:0]       Y_LAST  = 16'(V_ACTIVE - 1);
    localparam logic [15:0]       HB_LAST = 16'((H_BLANK > 0) ? H_BLANK - 1 : 0);
    localparam logic [15:0]       VB_LAST = 16'((V_BLANK > 0) ? V_BLANK - 1 : 0);
    localparam logic [DATA_W-1:0] BG      = DATA_W'(BG_LEVEL);

    state_t            state, state_nxt;
    logic [15:0]       xc, xc_nxt, yc, yc_nxt, bc, bc_nxt;
    logic              pending, pending_nxt;
    logic              capture, line_end;
    logic [15:0]       sx0, sx1, sy0, sy1;
    logic [DATA_W-1:0] slevel;
    logic [15:0]       bx0, bx1, by0, by1;
    logic [DATA_W-1:0] blevel;

    function automatic logic [DATA_W-1:0] pixel(
        input logic [15:0] px, py, x0, x1, y0, y1,
        input logic [DATA_W-1:0] lvl);
        if (px >= x0 && px <= x1 && py >= y0 && py <= y1) return lvl;
        return BG;
    endfunction

    // The first pixel of a frame must already see the box being captured.
    assign bx0    = capture ? bus.box_x0    : sx0;
    assign bx1    = capture ? bus.box_x1    : sx1;
    assign by0    = capture ? bus.box_y0    : sy0;
    assign by1    = capture ? bus.box_y1    : sy1;
    assign blevel = capture ? bus.box_level : slevel;

    always_comb begin
        state_nxt = state;
        xc_nxt    = xc;
        yc_nxt    = yc;
        bc_nxt    = bc;
        capture   = 1'b0;
        line_end  = 1'b0;
        case (state)
            IDLE:   if (pending) capture = 1'b1;
            LINE: begin
                if (xc == X_LAST) begin
                    if (H_BLANK > 0) begin
                        state_nxt = HBLANK;
                        bc_nxt    = 16'd0;
                    end else begin
                        line_end = 1'b1;
                    end
                end else begin
                    xc_nxt = xc + 16'd1;
                end
            end
            HBLANK: if (bc == HB_LAST) line_end = 1'b1; else bc_nxt = bc + 16'd1;
            VBLANK: if (bc == VB_LAST) state_nxt = DONE; else bc_nxt = bc + 16'd1;
            DONE:   if (bus.cont || pending || bus.start) capture = 1'b1; else state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        if (line_end) begin
            if (yc == Y_LAST) begin
                state_nxt = (V_BLANK > 0) ? VBLANK : DONE;
                bc_nxt    = 16'd0;
            end else begin
                state_nxt = LINE;
                xc_nxt    = 16'd0;
                yc_nxt    = yc + 16'd1;
            end
        end
        if (capture) begin
            state_nxt = LINE;
            xc_nxt    = 16'd0;
            yc_nxt    = 16'd0;
        end
        // A request seen in IDLE also waits here, giving the one-cycle start latency.
        if (capture)                                     pending_nxt = 1'b0;
        else if (bus.start || (state == IDLE && bus.cont)) pending_nxt = 1'b1;
        else                                             pending_nxt = pending;
    end

    always_ff @(posedge iCLK or negedge iRST) begin
        if (!iRST) begin
            state          <= IDLE;
            xc             <= 16'd0;
            yc             <= 16'd0;
            bc             <= 16'd0;
            pending        <= 1'b0;
            sx0            <= 16'd0;
            sx1            <= 16'd0;
            sy0            <= 16'd0;
            sy1            <= 16'd0;
            slevel         <= '0;
            bus.data       <= '0;
            bus.dval       <= 1'b0;
            bus.x          <= 16'd0;
            bus.y          <= 16'd0;
            bus.frame_done <= 1'b0;
            bus.busy       <= 1'b0;
        end else begin
            state   <= state_nxt;
            xc      <= xc_nxt;
            yc      <= yc_nxt;
            bc      <= bc_nxt;
            pending <= pending_nxt;
            if (capture) begin
                sx0    <= bus.box_x0;
                sx1    <= bus.box_x1;
                sy0    <= bus.box_y0;
                sy1    <= bus.box_y1;
                slevel <= bus.box_level;
            end
            bus.dval       <= (state_nxt == LINE);
            bus.frame_done <= (state_nxt == DONE);
            bus.busy       <= (state_nxt != IDLE);
            if (state_nxt == LINE) begin
                bus.x    <= xc_nxt;
                bus.y    <= yc_nxt;
                bus.data <= pixel(xc_nxt, yc_nxt, bx0, bx1, by0, by1, blevel);
            end
        end
    end
endmodule

// File: doc/raster_box_source.md
Name: raster_box_source

Overview:
- Synthetic raster pixel-stream source producing the DVAL/DATA stream consumed by the row-extent measurement blocks (640x480, 10-bit, DVAL-qualified, raster order).
- Draws a constant background with one programmable rectangle at a programmable level, with horizontal and vertical blanking gaps.
- Bench and bring-up stimulus source for the crop/extent pipeline: a box with known Y1 yields a known YEND downstream.

Parameters:
- H_ACTIVE, 640, active pixels per line
- V_ACTIVE, 480, active lines per frame
- H_BLANK, 16, DVAL-low cycles after each line (0 allowed = back-to-back lines)
- V_BLANK, 64, DVAL-low cycles after the last line's H_BLANK, before frame end
- DATA_W, 10, pixel width
- BG_LEVEL, 1023, background pixel value

Ports:
- iCLK  in  1  clock
- iRST  in  1  asynchronous, active-low reset
- iSTART  in  1  single-cycle request to emit one frame
- iCONT  in  1  continuous mode: start a new frame immediately after each frame end
- iBOX_X0  in  16  box left column, inclusive
- iBOX_X1  in  16  box right column, inclusive
- iBOX_Y0  in  16  box top line, inclusive
- iBOX_Y1  in  16  box bottom line, inclusive
- iBOX_LEVEL  in  DATA_W  pixel value inside the box
- oDATA  out  DATA_W  pixel value, valid when oDVAL=1
- oDVAL  out  1  pixel valid
- oX  out  16  column of the current oDATA
- oY  out  16  line of the current oDATA
- oFRAME_DONE  out  1  one-cycle pulse at frame end
- oBUSY  out  1  high from first pixel through the oFRAME_DONE cycle

Behaviour:
- Reset (iRST low, asynchronous):
  - Outputs: oDATA=0, oDVAL=0, oX=0, oY=0, oFRAME_DONE=0, oBUSY=0.
  - Internal: state=IDLE, counters=0, pending-start flag=0, box shadow registers=0.
  - Reset mid-frame aborts immediately; no oFRAME_DONE is produced.
- All outputs are registered.
- Frame start:
  - Box inputs are captured into shadow registers on the cycle the frame starts.
  - Input changes during a frame do not affect that frame.
- FSM states: IDLE, LINE, HBLANK, VBLANK, DONE.
- IDLE:
  - If iSTART=1 or iCONT=1 at edge k, the frame starts: the state is LINE after edge k+1 (first-pixel latency 1 cycle).
  - The first pixel is oDVAL=1, oX=0, oY=0.
- LINE:
  - oDVAL=1 for exactly H_ACTIVE consecutive cycles; oX runs 0..H_ACTIVE-1, oY is constant.
  - After oX=H_ACTIVE-1: go to HBLANK, or, if H_BLANK=0, directly to the next line's x=0 (or to VBLANK after the last line).
- HBLANK:
  - H_BLANK cycles with oDVAL=0; oDATA/oX/oY hold their last values.
  - Then oY increments and LINE resumes at x=0.
  - After line V_ACTIVE-1, go to VBLANK instead.
- VBLANK: V_BLANK cycles with oDVAL=0 (V_BLANK=0 skips it), then DONE.
- DONE: one cycle with oFRAME_DONE=1 and oBUSY=1.
  - Next state is LINE (new frame, new shadow capture) if iCONT=1 or pending-start=1 at that edge; otherwise IDLE.
  - Pending-start clears when the new frame begins.
- iSTART while busy: sets pending-start, giving exactly one extra frame. Multiple pulses in one frame still give one frame.
- iCONT deasserted mid-frame: the current frame completes normally; no new frame unless pending-start is set.
- Pixel value: oDATA = iBOX_LEVEL(shadow) if X0<=x<=X1 and Y0<=y<=Y1, else BG_LEVEL.
  - Comparisons are 16-bit unsigned.
  - X0>X1 or Y0>Y1 means no box.
  - Bounds beyond the active area clip naturally.
- Per frame: exactly H_ACTIVE*V_ACTIVE DVAL-high cycles, no gaps within a line.
- Frame length in cycles: V_ACTIVE*(H_ACTIVE+H_BLANK) + V_BLANK + 1.

Test Plan:
- Reset then iSTART, box X0=200 X1=300 Y0=60 Y1=120, level 0 -> first DVAL one cycle after iSTART at (0,0) with data 1023.
  - Pixel (200,60)=0, (199,60)=1023, (300,120)=0, (301,120)=1023.
  - 307200 DVAL cycles; one oFRAME_DONE at cycle 307200+480*16+64.
- Same box fed into the row-extent consumer -> consumer reports YEND=120; box Y1=239 gives 239.
- iCONT=1 for 3 frames, box inputs changed mid-frame 2 -> frame 2 uses the old box and frame 3 the new one; exactly 3 DONE pulses after iCONT drops during frame 3.
- iSTART pulsed twice during frame 1 with iCONT=0 -> exactly 2 frames, then IDLE with oBUSY=0.
- H_BLANK=0, V_BLANK=0 build -> DVAL continuously high for 307200 cycles, DONE, then IDLE; X0=5 X1=4 yields all 1023.
- iRST low at line 100 -> all outputs 0 on the next sample with no DONE pulse; a fresh iSTART restarts at (0,0).
